read_cmd_arb: RTL and testbench

READ_CMD_ARB -- requirements
Module: read_cmd_arb

---
 rtl/vector_cache_pkg.sv | 21 ++
 rtl/read_cmd_arb_if.sv | 26 ++
 rtl/read_rr_arb.sv | 46 ++++
 rtl/read_cmd_arb.sv | 106 ++++++++++
 tb/tb_read_cmd_arb.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: read request payload and requester index constants.
package vector_cache_pkg;

    localparam int SRC_WEST  = 0;
    localparam int SRC_EAST  = 1;
    localparam int SRC_SOUTH = 2;
    localparam int SRC_NORTH = 3;
    localparam int SRC_EVICT = 4;

    localparam int SRC_IDX_W = 3;
    localparam int ADDR_W    = 12;
    localparam int RAM_ID_W  = 2;

    typedef logic [SRC_IDX_W-1:0] src_idx_t;

    typedef struct packed {
        logic [RAM_ID_W-1:0] dest_ram_id;
        logic [ADDR_W-1:0]   addr;
    } arb_out_req_t;

endpackage

// File: rtl/read_cmd_arb_if.sv
// Request/response bundle between the per-hash requesters and the read command arbiter.
interface read_cmd_arb_if
    import vector_cache_pkg::*;
#(
    parameter int HASH_NUM = 4,
    parameter int SRC_NUM  = 5
);

    logic         [HASH_NUM-1:0][SRC_NUM-1:0] v_req_vld;
    arb_out_req_t [HASH_NUM-1:0][SRC_NUM-1:0] v_req_pld;
    logic         [HASH_NUM-1:0][SRC_NUM-1:0] v_req_rdy;
    logic         [HASH_NUM-1:0]              v_out_vld;
    arb_out_req_t [HASH_NUM-1:0]              v_out_pld;
    src_idx_t     [HASH_NUM-1:0]              v_out_src;

    modport master (
        output v_req_vld, v_req_pld,
        input  v_req_rdy, v_out_vld, v_out_pld, v_out_src
    );

    modport slave (
        input  v_req_vld, v_req_pld,
        output v_req_rdy, v_out_vld, v_out_pld, v_out_src
    );

endinterface

// File: rtl/read_rr_arb.sv
// Round-robin pick among eligible sources of one hash; the pointer advances past each winner.
module read_rr_arb
    import vector_cache_pkg::*;
#(
    parameter int SRC_NUM = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SRC_NUM-1:0] elig,
    output logic [SRC_NUM-1:0] gnt,
    output logic               gnt_vld,
    output src_idx_t           gnt_idx
);

    localparam src_idx_t LAST_SRC = src_idx_t'(SRC_NUM - 1);

    src_idx_t ptr;
    src_idx_t cand;

    // Walk sources starting at ptr; ineligible ones are skipped without moving ptr.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            cand = src_idx_t'((int'(ptr) + k) % SRC_NUM);
            for (int s = 0; s < SRC_NUM; s++) begin
                if (!gnt_vld && elig[s] && (cand == src_idx_t'(s))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                    gnt[s]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/read_cmd_arb.sv
// Per-hash read command arbiter: round-robin among requesters, gated by per-bank RAM busy
// counters, with the winning command registered for one cycle on the output.
module read_cmd_arb
    import vector_cache_pkg::*;
#(
    parameter int HASH_NUM    = 4,
    parameter int SRC_NUM     = 5,
    parameter int RD_BUSY_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    read_cmd_arb_if.slave  bus
);

    localparam int              BW        = $clog2(RD_BUSY_CYC + 1);
    localparam logic [BW-1:0]   BUSY_LOAD = BW'(RD_BUSY_CYC - 1);

    // Each hash owns two banks: bank 2*i + dest_ram_id[0], stored here as [i][dest bit].
    logic [BW-1:0]                       busy_cnt [HASH_NUM][2];
    logic         [HASH_NUM-1:0][1:0]    bank_busy;
    logic         [HASH_NUM-1:0][SRC_NUM-1:0] elig;
    logic         [HASH_NUM-1:0][SRC_NUM-1:0] gnt;
    logic         [HASH_NUM-1:0]         gnt_vld;
    src_idx_t     [HASH_NUM-1:0]         gnt_idx;
    arb_out_req_t [HASH_NUM-1:0]         gnt_pld;

    always_comb begin
        bank_busy = '0;
        for (int i = 0; i < HASH_NUM; i++) begin
            for (int d = 0; d < 2; d++) begin
                bank_busy[i][d] = (busy_cnt[i][d] != '0);
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < HASH_NUM; i++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                elig[i][s] = bus.v_req_vld[i][s] &&
                             !bank_busy[i][bus.v_req_pld[i][s].dest_ram_id[0]];
            end
        end
    end

    for (genvar i = 0; i < HASH_NUM; i++) begin : g_hash
        read_rr_arb #(
            .SRC_NUM (SRC_NUM)
        ) u_rr (
            .clk     (clk),
            .rst_n   (rst_n),
            .elig    (elig[i]),
            .gnt     (gnt[i]),
            .gnt_vld (gnt_vld[i]),
            .gnt_idx (gnt_idx[i])
        );
    end

    always_comb begin
        gnt_pld = '0;
        for (int i = 0; i < HASH_NUM; i++) begin
            gnt_pld[i] = bus.v_req_pld[i][gnt_idx[i]];
        end
    end

    // Grants are masked while reset is asserted so no requester sees a phantom handshake.
    assign bus.v_req_rdy = rst_n ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HASH_NUM; i++) begin
                for (int d = 0; d < 2; d++) begin
                    busy_cnt[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < HASH_NUM; i++) begin
                for (int d = 0; d < 2; d++) begin
                    if (gnt_vld[i] && (gnt_pld[i].dest_ram_id[0] == 1'(d))) begin
                        busy_cnt[i][d] <= BUSY_LOAD;
                    end else if (busy_cnt[i][d] != '0) begin
                        busy_cnt[i][d] <= busy_cnt[i][d] - BW'(1);
                    end
                end
            end
        end
    end

    // Payload and source hold their last value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.v_out_vld <= '0;
            bus.v_out_pld <= '0;
            bus.v_out_src <= '0;
        end else begin
            bus.v_out_vld <= gnt_vld;
            for (int i = 0; i < HASH_NUM; i++) begin
                if (gnt_vld[i]) begin
                    bus.v_out_pld[i] <= gnt_pld[i];
                    bus.v_out_src[i] <= gnt_idx[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_read_cmd_arb.sv
// Scoreboard bench for read_cmd_arb at RD_BUSY_CYC = 2, 1 and 8.
module tb_read_cmd_arb;
    import vector_cache_pkg::*;

    localparam int HN = 4;
    localparam int SN = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           src;
        arb_out_req_t pld;
        int           cyc;
    } exp_t;

    exp_t exp_q [3][HN][$];

    read_cmd_arb_if #(.HASH_NUM(HN), .SRC_NUM(SN)) if2 ();
    read_cmd_arb_if #(.HASH_NUM(HN), .SRC_NUM(SN)) if1 ();
    read_cmd_arb_if #(.HASH_NUM(HN), .SRC_NUM(SN)) if8 ();

    read_cmd_arb #(.HASH_NUM(HN), .SRC_NUM(SN), .RD_BUSY_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));
    read_cmd_arb #(.HASH_NUM(HN), .SRC_NUM(SN), .RD_BUSY_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    read_cmd_arb #(.HASH_NUM(HN), .SRC_NUM(SN), .RD_BUSY_CYC(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));

    function automatic arb_out_req_t mk(input int dest, input int addr);
        arb_out_req_t p;
        p.dest_ram_id = RAM_ID_W'(dest);
        p.addr        = ADDR_W'(addr);
        return p;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic apply_stimulus_expect(input int inst, input int h, input int src,
                                         input arb_out_req_t pld);
        exp_t e;
        e.src = src;
        e.pld = pld;
        e.cyc = cyc + 1;
        exp_q[inst][h].push_back(e);
    endtask

    task automatic check_output(input int inst, input int h, input src_idx_t src,
                                input arb_out_req_t pld);
        exp_t e;
        checks++;
        if (exp_q[inst][h].size() == 0) begin
            errors++;
            $display("[TB] FAIL out_unexpected inst=%0d hash=%0d actual src=%0d pld=%0h required none cyc=%0d",
                     inst, h, src, pld, cyc);
        end else begin
            e = exp_q[inst][h].pop_front();
            if (int'(src) != e.src || pld !== e.pld || cyc != e.cyc) begin
                errors++;
                $display("[TB] FAIL out_inst%0d_hash%0d actual src=%0d pld=%0h cyc=%0d required src=%0d pld=%0h cyc=%0d",
                         inst, h, src, pld, cyc, e.src, e.pld, e.cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        if2.v_req_vld = '0; if2.v_req_pld = '0;
        if1.v_req_vld = '0; if1.v_req_pld = '0;
        if8.v_req_vld = '0; if8.v_req_pld = '0;
    endtask

    // Monitors: every output pulse is matched against the head of its scoreboard queue.
    always @(negedge clk) begin
        for (int h = 0; h < HN; h++) begin
            if (if2.v_out_vld[h]) check_output(0, h, if2.v_out_src[h], if2.v_out_pld[h]);
        end
    end
    always @(negedge clk) begin
        for (int h = 0; h < HN; h++) begin
            if (if1.v_out_vld[h]) check_output(1, h, if1.v_out_src[h], if1.v_out_pld[h]);
        end
    end
    always @(negedge clk) begin
        for (int h = 0; h < HN; h++) begin
            if (if8.v_out_vld[h]) check_output(2, h, if8.v_out_src[h], if8.v_out_pld[h]);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    int           addr1 [SN];
    int           a3;
    int           a8;
    int           g;
    logic [31:0]  exp_rdy;

    initial begin
        clear_all();
        rst_n = 1'b0;
        repeat (2) tick();

        // Reset state, with a request present
        if2.v_req_vld[0][0] = 1'b1;
        @(negedge clk);
        check_val("reset_rdy", 32'(if2.v_req_rdy), 32'h0);
        check_val("reset_out_vld", 32'(if2.v_out_vld), 32'h0);
        check_val("reset_out_pld", 32'(if2.v_out_pld), 32'h0);
        check_val("reset_out_src", 32'(if2.v_out_src), 32'h0);
        tick();
        clear_all();
        rst_n = 1'b1;
        tick();

        // Hash 0: west then evict to the same bank, RD_BUSY_CYC=2
        if2.v_req_vld[0][SRC_WEST]  = 1'b1; if2.v_req_pld[0][SRC_WEST]  = mk(0, 'h100);
        if2.v_req_vld[0][SRC_EVICT] = 1'b1; if2.v_req_pld[0][SRC_EVICT] = mk(2, 'h104);
        @(negedge clk);
        check_val("a_rdy_t0", 32'(if2.v_req_rdy[0]), 32'b00001);
        apply_stimulus_expect(0, 0, SRC_WEST, mk(0, 'h100));
        tick();
        if2.v_req_vld[0][SRC_WEST] = 1'b0;
        @(negedge clk);
        check_val("a_rdy_t1_busy", 32'(if2.v_req_rdy[0]), 32'b00000);
        tick();
        @(negedge clk);
        check_val("a_rdy_t2", 32'(if2.v_req_rdy[0]), 32'b10000);
        apply_stimulus_expect(0, 0, SRC_EVICT, mk(2, 'h104));
        tick();
        clear_all();

        // Hash 1: west to bank 2, east to bank 3
        if2.v_req_vld[1][SRC_WEST] = 1'b1; if2.v_req_pld[1][SRC_WEST] = mk(0, 'h200);
        if2.v_req_vld[1][SRC_EAST] = 1'b1; if2.v_req_pld[1][SRC_EAST] = mk(1, 'h208);
        @(negedge clk);
        check_val("b_rdy_t0", 32'(if2.v_req_rdy[1]), 32'b00001);
        apply_stimulus_expect(0, 1, SRC_WEST, mk(0, 'h200));
        tick();
        if2.v_req_vld[1][SRC_WEST] = 1'b0;
        @(negedge clk);
        check_val("b_rdy_t1", 32'(if2.v_req_rdy[1]), 32'b00010);
        apply_stimulus_expect(0, 1, SRC_EAST, mk(1, 'h208));
        tick();
        clear_all();
        repeat (3) tick();

        // All four hashes at once, four distinct banks
        if2.v_req_vld[0][SRC_NORTH] = 1'b1; if2.v_req_pld[0][SRC_NORTH] = mk(0, 'h500);
        if2.v_req_vld[1][SRC_SOUTH] = 1'b1; if2.v_req_pld[1][SRC_SOUTH] = mk(1, 'h510);
        if2.v_req_vld[2][SRC_EAST]  = 1'b1; if2.v_req_pld[2][SRC_EAST]  = mk(0, 'h520);
        if2.v_req_vld[3][SRC_EVICT] = 1'b1; if2.v_req_pld[3][SRC_EVICT] = mk(1, 'h530);
        @(negedge clk);
        check_val("c_rdy_h0", 32'(if2.v_req_rdy[0]), 32'b01000);
        check_val("c_rdy_h1", 32'(if2.v_req_rdy[1]), 32'b00100);
        check_val("c_rdy_h2", 32'(if2.v_req_rdy[2]), 32'b00010);
        check_val("c_rdy_h3", 32'(if2.v_req_rdy[3]), 32'b10000);
        apply_stimulus_expect(0, 0, SRC_NORTH, mk(0, 'h500));
        apply_stimulus_expect(0, 1, SRC_SOUTH, mk(1, 'h510));
        apply_stimulus_expect(0, 2, SRC_EAST,  mk(0, 'h520));
        apply_stimulus_expect(0, 3, SRC_EVICT, mk(1, 'h530));
        tick();
        clear_all();
        @(negedge clk);
        check_val("c_out_vld_all", 32'(if2.v_out_vld), 32'b1111);
        tick();

        // RD_BUSY_CYC=1: full rotation on hash 2, back-to-back same bank on hash 3
        for (int s = 0; s < SN; s++) begin
            addr1[s] = 'h600 + s;
            if1.v_req_vld[2][s] = 1'b1;
            if1.v_req_pld[2][s] = mk(s % 2, addr1[s]);
        end
        a3 = 'h700;
        if1.v_req_vld[3][0] = 1'b1;
        if1.v_req_pld[3][0] = mk(0, a3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = k % SN;
            exp_rdy = 32'(1) << g;
            check_val($sformatf("d_rdy_h2_k%0d", k), 32'(if1.v_req_rdy[2]), exp_rdy);
            apply_stimulus_expect(1, 2, g, mk(g % 2, addr1[g]));
            if (k < 3) begin
                check_val($sformatf("d_rdy_h3_k%0d", k), 32'(if1.v_req_rdy[3]), 32'b00001);
                apply_stimulus_expect(1, 3, 0, mk(0, a3));
            end
            tick();
            addr1[g] = addr1[g] + 16;
            if1.v_req_pld[2][g] = mk(g % 2, addr1[g]);
            if (k < 2) begin
                a3 = a3 + 16;
                if1.v_req_pld[3][0] = mk(0, a3);
            end else begin
                if1.v_req_vld[3][0] = 1'b0;
            end
        end
        clear_all();
        repeat (3) tick();

        // RD_BUSY_CYC=8: reset right after a grant clears output, busy state and pointer
        if8.v_req_vld[0][SRC_SOUTH] = 1'b1; if8.v_req_pld[0][SRC_SOUTH] = mk(0, 'h200);
        @(negedge clk);
        check_val("r_rdy_pre", 32'(if8.v_req_rdy[0]), 32'b00100);
        tick();
        check_val("r_out_vld_pre", 32'(if8.v_out_vld[0]), 32'h1);
        check_val("r_out_src_pre", 32'(if8.v_out_src[0]), 32'(SRC_SOUTH));
        rst_n = 1'b0;
        #1;
        check_val("r_out_vld_async", 32'(if8.v_out_vld[0]), 32'h0);
        check_val("r_out_src_async", 32'(if8.v_out_src[0]), 32'h0);
        if8.v_req_vld[0][SRC_SOUTH] = 1'b0;
        if8.v_req_vld[0][SRC_EAST]  = 1'b1; if8.v_req_pld[0][SRC_EAST]  = mk(0, 'h210);
        if8.v_req_vld[0][SRC_NORTH] = 1'b1; if8.v_req_pld[0][SRC_NORTH] = mk(2, 'h230);
        @(negedge clk);
        check_val("r_rdy_in_reset", 32'(if8.v_req_rdy[0]), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("r_rdy_post", 32'(if8.v_req_rdy[0]), 32'b00010);
        apply_stimulus_expect(2, 0, SRC_EAST, mk(0, 'h210));
        tick();
        clear_all();
        repeat (10) tick();

        // RD_BUSY_CYC=8: evict hammering bank 0 is granted every 8th cycle only
        a8 = 'h300;
        if8.v_req_vld[0][SRC_EVICT] = 1'b1;
        if8.v_req_pld[0][SRC_EVICT] = mk(0, a8);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_rdy = (k % 8 == 0) ? 32'b10000 : 32'b00000;
            check_val($sformatf("e_rdy_k%0d", k), 32'(if8.v_req_rdy[0]), exp_rdy);
            if (k % 8 == 0) apply_stimulus_expect(2, 0, SRC_EVICT, mk(0, a8));
            tick();
            if (k % 8 == 0) begin
                a8 = a8 + 16;
                if8.v_req_pld[0][SRC_EVICT] = mk(0, a8);
            end
        end
        clear_all();
        repeat (4) tick();

        for (int i = 0; i < 3; i++) begin
            for (int h = 0; h < HN; h++) begin
                checks++;
                if (exp_q[i][h].size() != 0) begin
                    errors++;
                    $display("[TB] FAIL drain_inst%0d_hash%0d actual pending=%0d required 0",
                             i, h, exp_q[i][h].size());
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
